// File: rtl/snn_chk_pkg.sv
// Shared types and helpers for the SNN result checker.
// State encoding plus the channel-slice offset helper used by the top.
package snn_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_ABORT
    } chk_state_e;

    localparam int CH_DW_DEF = 16;

    function automatic int ch_lo(input int ch, input int dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/snn_result_checker_if.sv
// Expected-result valid/ready bundle feeding the SNN result checker.
// Master is the reference source, slave is the checker.
interface snn_result_checker_if #(
    parameter int NCH = 2,
    parameter int DW  = 16
);
    logic                exp_valid;
    logic                exp_ready;
    logic [NCH*DW-1:0]   exp_data;

    modport master (
        output exp_valid,
        output exp_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid,
        input  exp_data,
        output exp_ready
    );
endinterface

// File: rtl/snn_stride_cnt.sv
// Stride/phase counter: counts output-buffer strobes per inference
// and numbers each inference at its phase-0 strobe.
module snn_stride_cnt #(
    parameter int CW = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          load,
    input  logic [CW-1:0] stride,
    input  logic          step,
    output logic          phase_zero,
    output logic [CW-1:0] smp_idx
);

    logic [CW-1:0] stride_q;
    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_nxt;

    assign phase_zero = (phase_q == '0);
    assign phase_nxt  = phase_q + 1'b1;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            stride_q <= '0;
            phase_q  <= '0;
            smp_idx  <= '0;
        end else if (load) begin
            stride_q <= (stride == '0) ? CW'(1) : stride;
            phase_q  <= '0;
            smp_idx  <= '0;
        end else if (step) begin
            // a zero stride_q (only before the first load) behaves as 1
            phase_q <= (phase_nxt >= stride_q) ? '0 : phase_nxt;
            if (phase_zero) begin
                smp_idx <= smp_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_result_checker.sv
// Compares SNN output samples against expected results.
// Optional first-error capture: define SNN_CHK_FIRST_ERR_EN.
module snn_result_checker
    import snn_chk_pkg::*;
#(
    parameter int              NCH      = 2,
    parameter int              DW       = 16,
    parameter int              CW       = 32,
    parameter int              MAX_ERR  = 1000,
    parameter logic [NCH-1:0]  CMP_MASK = 1
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              start,
    input  logic [CW-1:0]     stride,
    input  logic              valid_in,
    input  logic [NCH*DW-1:0] data_in,
    input  logic              exp_valid,
    input  logic [NCH*DW-1:0] exp_data,
    output logic              exp_ready,
    output logic              res_valid,
    output logic [CW-1:0]     res_idx,
    output logic              mismatch,
    output logic [CW-1:0]     err_cnt,
    output logic              overflow,
    output logic              abort
`ifdef SNN_CHK_FIRST_ERR_EN
    ,
    output logic              first_err_vld,
    output logic [CW-1:0]     first_err_idx,
    output logic [NCH*DW-1:0] first_err_got
`endif
);

    localparam logic [CW:0] MAX_ERR_W = (CW+1)'(MAX_ERR);

    chk_state_e state_q, state_d;

    logic              step;
    logic              phase_zero;
    logic              cap_evt;
    logic [CW-1:0]     smp_idx;
    logic              cap_en;
    logic              drop;
    logic              xfer;
    logic              ready_c;
    logic              mis_c;
    logic              abort_c;
    logic [CW-1:0]     err_inc;
    logic [NCH*DW-1:0] hold_q;
    logic [CW-1:0]     hold_idx;

    assign step    = valid_in &&
                     (state_q == ST_RUN || state_q == ST_HOLD);
    assign cap_evt = step && phase_zero;

    snn_stride_cnt #(
        .CW(CW)
    ) u_cnt (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .load      (start),
        .stride    (stride),
        .step      (step),
        .phase_zero(phase_zero),
        .smp_idx   (smp_idx)
    );

    always_comb begin
        mis_c = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (CMP_MASK[i] &&
                ($signed(hold_q[ch_lo(i, DW) +: DW]) !=
                 $signed(exp_data[ch_lo(i, DW) +: DW]))) begin
                mis_c = 1'b1;
            end
        end
    end

    assign err_inc = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
    assign abort_c = ({1'b0, err_inc} > MAX_ERR_W);

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        drop    = 1'b0;
        xfer    = 1'b0;
        ready_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_RUN: begin
                if (cap_evt) begin
                    cap_en  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                ready_c = 1'b1;
                xfer    = exp_valid;
                // a new sample can only land if the old one leaves now
                cap_en  = cap_evt && exp_valid;
                drop    = cap_evt && !exp_valid;
                if (exp_valid && !cap_evt) begin
                    state_d = ST_RUN;
                end
                if (exp_valid && mis_c && abort_c) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start) begin
            state_d = ST_RUN;
        end
    end

    assign exp_ready = ready_c;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n || start) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            mismatch  <= 1'b0;
            err_cnt   <= '0;
            overflow  <= 1'b0;
            abort     <= 1'b0;
            hold_q    <= '0;
            hold_idx  <= '0;
        end else begin
            res_valid <= xfer;
            if (xfer) begin
                res_idx  <= hold_idx;
                mismatch <= mis_c;
                if (mis_c) begin
                    err_cnt <= err_inc;
                    if (abort_c) begin
                        abort <= 1'b1;
                    end
                end
            end
            if (cap_en) begin
                hold_q   <= data_in;
                hold_idx <= smp_idx;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SNN_CHK_FIRST_ERR_EN
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n || start) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_got <= '0;
        end else if (xfer && mis_c && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= hold_idx;
            first_err_got <= hold_q;
        end
    end
`endif

endmodule
